// File: rtl/video_timing_gen.sv
// video_timing_gen: runtime-reprogrammable raster timing generator.
// Free-running h/v counters walk the frame described by the active timing
// set. A new timing set arrives on a valid/ready port, is checked, parked in
// a shadow register and swapped in only at the last pixel of a frame, so
// every frame is produced entirely under one timing set. All outputs are
// registered one cycle behind the counters.
//
// Config handshake: a word transfers on any rising clk_pix edge where
// cfg_valid && cfg_ready. The source holds cfg_valid and the fields stable
// until that edge; the block never drops a word, it only stalls it by
// holding cfg_ready low while a checked word is waiting to be applied.
// A word that fails the ordering check still transfers (cfg_ready stays
// high) but is discarded and flagged by a one-cycle cfg_err pulse.
module video_timing_gen #(
  parameter int unsigned CW         = 12,
  parameter int unsigned H_ACT_END  = 1279,
  parameter int unsigned H_SYNC_STA = 1287,
  parameter int unsigned H_SYNC_END = 1319,
  parameter int unsigned H_LINE     = 1359,
  parameter int unsigned V_ACT_END  = 719,
  parameter int unsigned V_SYNC_STA = 726,
  parameter int unsigned V_SYNC_END = 734,
  parameter int unsigned V_SCREEN   = 740,
  parameter logic        H_POL      = 1'b0,
  parameter logic        V_POL      = 1'b0
) (
  input  logic          clk_pix,
  input  logic          rst_pix,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_h_act_end,
  input  logic [CW-1:0] cfg_h_sync_sta,
  input  logic [CW-1:0] cfg_h_sync_end,
  input  logic [CW-1:0] cfg_h_line,
  input  logic [CW-1:0] cfg_v_act_end,
  input  logic [CW-1:0] cfg_v_sync_sta,
  input  logic [CW-1:0] cfg_v_sync_end,
  input  logic [CW-1:0] cfg_v_screen,
  input  logic          cfg_h_pol,
  input  logic          cfg_v_pol,
  output logic          cfg_err,
  output logic [CW-1:0] sx,
  output logic [CW-1:0] sy,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  // Config slot state: IDLE = slot free, PEND = checked word waiting for
  // the frame boundary. cfg_ready is a direct decode of this state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Active timing set.
  logic [CW-1:0] act_h_act_end, act_h_sync_sta, act_h_sync_end, act_h_line;
  logic [CW-1:0] act_v_act_end, act_v_sync_sta, act_v_sync_end, act_v_screen;
  logic          act_h_pol, act_v_pol;

  // Shadow timing set, valid while state == ST_PEND.
  logic [CW-1:0] shd_h_act_end, shd_h_sync_sta, shd_h_sync_end, shd_h_line;
  logic [CW-1:0] shd_v_act_end, shd_v_sync_sta, shd_v_sync_end, shd_v_screen;
  logic          shd_h_pol, shd_v_pol;

  logic [CW-1:0] h, v;
  logic          accept, cfg_ok, h_end, v_end, boundary, apply;

  assign cfg_ready = (state == ST_IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_ok    = (cfg_h_act_end  <  cfg_h_sync_sta) &&
                     (cfg_h_sync_sta <  cfg_h_sync_end) &&
                     (cfg_h_sync_end <= cfg_h_line)     &&
                     (cfg_v_act_end  <  cfg_v_sync_sta) &&
                     (cfg_v_sync_sta <  cfg_v_sync_end) &&
                     (cfg_v_sync_end <= cfg_v_screen);
  assign h_end     = (h == act_h_line);
  assign v_end     = (v == act_v_screen);
  assign boundary  = h_end && v_end;
  // Only a word that was already pending when the boundary cycle began is
  // applied, so a word accepted on the boundary waits a whole frame.
  assign apply     = (state == ST_PEND) && boundary;

  // Slot state register.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Slot next-state: fill on a good accept, empty on apply.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && cfg_ok) state_nxt = ST_PEND;
      ST_PEND: if (boundary)         state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shadow capture of a checked config word.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      shd_h_act_end  <= '0;
      shd_h_sync_sta <= '0;
      shd_h_sync_end <= '0;
      shd_h_line     <= '0;
      shd_v_act_end  <= '0;
      shd_v_sync_sta <= '0;
      shd_v_sync_end <= '0;
      shd_v_screen   <= '0;
      shd_h_pol      <= 1'b0;
      shd_v_pol      <= 1'b0;
    end else if (accept && cfg_ok) begin
      shd_h_act_end  <= cfg_h_act_end;
      shd_h_sync_sta <= cfg_h_sync_sta;
      shd_h_sync_end <= cfg_h_sync_end;
      shd_h_line     <= cfg_h_line;
      shd_v_act_end  <= cfg_v_act_end;
      shd_v_sync_sta <= cfg_v_sync_sta;
      shd_v_sync_end <= cfg_v_sync_end;
      shd_v_screen   <= cfg_v_screen;
      shd_h_pol      <= cfg_h_pol;
      shd_v_pol      <= cfg_v_pol;
    end
  end

  // Active timing set: defaults on reset, shadow copy at the frame boundary.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      act_h_act_end  <= CW'(H_ACT_END);
      act_h_sync_sta <= CW'(H_SYNC_STA);
      act_h_sync_end <= CW'(H_SYNC_END);
      act_h_line     <= CW'(H_LINE);
      act_v_act_end  <= CW'(V_ACT_END);
      act_v_sync_sta <= CW'(V_SYNC_STA);
      act_v_sync_end <= CW'(V_SYNC_END);
      act_v_screen   <= CW'(V_SCREEN);
      act_h_pol      <= H_POL;
      act_v_pol      <= V_POL;
    end else if (apply) begin
      act_h_act_end  <= shd_h_act_end;
      act_h_sync_sta <= shd_h_sync_sta;
      act_h_sync_end <= shd_h_sync_end;
      act_h_line     <= shd_h_line;
      act_v_act_end  <= shd_v_act_end;
      act_v_sync_sta <= shd_v_sync_sta;
      act_v_sync_end <= shd_v_sync_end;
      act_v_screen   <= shd_v_screen;
      act_h_pol      <= shd_h_pol;
      act_v_pol      <= shd_v_pol;
    end
  end

  // Raster counters; the apply cycle is always a wrap to h=v=0.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      h <= '0;
      v <= '0;
    end else if (h_end) begin
      h <= '0;
      v <= v_end ? '0 : v + CW'(1);
    end else begin
      h <= h + CW'(1);
    end
  end

  // Rejected-config pulse, one cycle after the offending transfer.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) cfg_err <= 1'b0;
    else         cfg_err <= accept && !cfg_ok;
  end

  // Registered raster outputs, one cycle behind h/v.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      sx          <= '0;
      sy          <= '0;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
    end else begin
      sx          <= h;
      sy          <= v;
      de          <= (h <= act_h_act_end) && (v <= act_v_act_end);
      line_start  <= (h == '0);
      frame_start <= (h == '0) && (v == '0);
      hsync       <= ((h >= act_h_sync_sta) && (h < act_h_sync_end)) ^ ~act_h_pol;
      vsync       <= ((v >= act_v_sync_sta) && (v < act_v_sync_end)) ^ ~act_v_pol;
    end
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised, runtime-reprogrammable video timing generator.
- Successor to the fixed 720p VGA timing controller.
- Default timings and counter width are set by parameters. Timings can be reloaded at run time through a valid/ready config port. A new config takes effect only at a frame boundary, so no torn frames are produced.
- Adds per-axis sync polarity, line-start and frame-start strobes, registered outputs, and config validation. Feeds the pixel pipeline and the display PHY.

Parameters:
CW, 12, counter and timing-field width in bits
H_ACT_END, 1279, reset default: last active pixel
H_SYNC_STA, 1287, reset default: first hsync pixel
H_SYNC_END, 1319, reset default: first pixel after hsync
H_LINE, 1359, reset default: last pixel of line
V_ACT_END, 719, reset default: last active line
V_SYNC_STA, 726, reset default: first vsync line
V_SYNC_END, 734, reset default: first line after vsync
V_SCREEN, 740, reset default: last line of frame
H_POL, 0, reset default hsync polarity (0 = active-low)
V_POL, 0, reset default vsync polarity (0 = active-low)

Ports:
clk_pix  in  1  pixel clock
rst_pix  in  1  synchronous active-high reset, pixel clock domain
cfg_valid  in  1  config word valid
cfg_ready  out  1  config slot free
cfg_h_act_end, cfg_h_sync_sta, cfg_h_sync_end, cfg_h_line  in  CW each  horizontal timing fields
cfg_v_act_end, cfg_v_sync_sta, cfg_v_sync_end, cfg_v_screen  in  CW each  vertical timing fields
cfg_h_pol, cfg_v_pol  in  1 each  sync polarities (1 = active-high)
cfg_err  out  1  one-cycle pulse: rejected config
sx  out  CW  horizontal position
sy  out  CW  vertical position
hsync  out  1  horizontal sync, programmed polarity
vsync  out  1  vertical sync, programmed polarity
de  out  1  data enable
line_start  out  1  pulse at sx==0
frame_start  out  1  pulse at sx==0 and sy==0

Behaviour:
Clock and reset:
- One clock: clk_pix. rst_pix is synchronous and active-high.

Counters:
- Internal counters h and v, CW bits wide.
- h increments every cycle. When h==line it wraps to 0 and v advances.
- v wraps to 0 when v==screen, evaluated on the h==line cycle.

Outputs:
- All outputs are registered, with 1 cycle of latency from the counters.
- sx/sy equal h/v of the previous cycle. All strobes and syncs are aligned to sx/sy.
- de = (h<=act_end_h) && (v<=act_end_v).
- Sync is active when sta<=cnt<sync_end. Output level = active XOR ~pol.

Reset:
- h, v, sx, sy = 0. de, line_start, frame_start, cfg_err = 0.
- hsync = ~H_POL, vsync = ~V_POL (inactive levels).
- Active timings revert to the parameter defaults. Pending config is cleared. cfg_ready = 1.
- First cycle after reset release: sx=0, sy=0, de=1, line_start=1, frame_start=1.
- Reset mid-frame: same result. The pending config is discarded.

Config handshake:
- Accept occurs when cfg_valid && cfg_ready. All fields are captured into a shadow register.
- Validation requires act_end < sync_sta < sync_end <= line on the horizontal axis, and the same on the vertical axis (with screen in place of line).
- Invalid config: not stored. cfg_err=1 for exactly the next cycle. cfg_ready stays 1. Active timings are unchanged.
- Valid config: pending=1 from the next cycle, so cfg_ready=0.
- Further cfg_valid while pending is ignored. The source must hold valid; it is not dropped by the block.

Apply:
- Applies on the first cycle with pending=1 and h==line && v==screen.
- The next cycle has h=0, v=0 under the new timings. pending clears and cfg_ready=1 in that same cycle.
- An accept occurring on a boundary cycle applies at the following boundary, not the current one.

Arithmetic:
- Comparisons are unsigned CW-bit.
- Counters never exceed line/screen because timings change only when h=v=0.

Test Plan:
- Reset defaults -> line_start period 1360 cycles. frame_start period 1360*741=1007760 cycles. hsync=0 for sx 1287..1318. vsync=0 for sy 726..733. de=1 exactly 1280 cycles per line for sy 0..719.
- Mid-frame cfg accept: h 9/11/13/15, v 3/4/5/6, pol 1/1 -> cfg_ready drops next cycle. The old timing continues to the frame end. New frame: line period 16, frame period 112, hsync=1 for sx 11..12, vsync=1 for sy 4, de for sx 0..9 and sy 0..3. cfg_ready=1 again at the frame_start cycle.
- Second cfg_valid held while pending -> not accepted until cfg_ready rises. Accepted the cycle after, then applied at the following boundary.
- Invalid cfg (h_sync_sta=5 < h_act_end=9) -> cfg_err one pulse, no timing change, cfg_ready stays 1.
- Accept on the exact boundary cycle (h==line, v==screen) -> new timings start one frame later.
- rst_pix asserted mid-line with pending config -> outputs return to reset values and the pending config is lost. After release, 720p default timing with frame_start=1 on the first cycle.
